custom_leds_pwm: RTL and testbench
==================================

CUSTOM_LEDS_PWM -- requirements
Module: custom_leds_pwm

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 8, number of LED channels, legal range 1..32.
REQ-002 SHALL have parameter PWM_BITS, default 8, PWM counter and duty width, legal range 2..16.
REQ-003 SHALL have port clk_clk, input, 1 bit; the single clock, all logic rising-edge.
REQ-004 SHALL have port reset_reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 SHALL have port avs_s0_address, input, 6 bits; word register address.
REQ-006 SHALL have ports avs_s0_write and avs_s0_read, input, 1 bit each; access strobes.
REQ-007 SHALL have port avs_s0_writedata, input, 32 bits; write data.
REQ-008 SHALL have port avs_s0_readdata, output, 32 bits; registered read data.
REQ-009 SHALL have port leds, output, NUM_LEDS bits; registered LED drive.

Function
REQ-010 SHALL decode registers: 0x00 CTRL [0]=GEN global enable, [1]=INV output invert, [2]=CLR self-clearing counter clear; 0x01 EN mask; 0x02 BLINK mask; 0x03 PRESCALE[15:0]; 0x04 BPER[15:0]; 0x20+i DUTY[i] (PWM_BITS), i<NUM_LEDS.
REQ-011 SHALL read back stored values, zero-extended; CLR reads 0; unmapped or i>=NUM_LEDS addresses read 0, writes ignored.
REQ-012 SHALL present avs_s0_readdata exactly 1 cycle after the read strobe, no wait states; readdata holds its value when no read is issued.
REQ-013 SHALL run prescaler pcnt 0..PRESCALE, emitting a 1-cycle tick when pcnt==PRESCALE, then pcnt=0; PRESCALE=0 ticks every cycle.
REQ-014 SHALL advance PWM counter cnt by 1 on each tick, wrapping from 2^PWM_BITS-1 to 0; the wrap cycle is the period boundary.
REQ-015 SHALL double-buffer DUTY: writes land in a shadow register; active duty loads from the shadow only at the period boundary.
REQ-016 SHALL compute raw[i]=1 when active duty[i]==2^PWM_BITS-1 (100%), else when cnt<active duty[i]; duty 0 gives constant 0.
REQ-017 SHALL count completed periods in bcnt 0..BPER and toggle phase at bcnt==BPER (bcnt to 0); BPER=0 toggles every period.
REQ-018 SHALL form on[i]=GEN & EN[i] & raw[i] & (~BLINK[i] | phase).
REQ-019 SHALL register leds[i]=on[i]^INV, one cycle after the cnt value that produced it.
REQ-020 SHALL on a CLR write zero pcnt, cnt, bcnt and phase on the next edge, and load active duty from the shadow; a simultaneous tick is discarded.
REQ-021 SHALL apply PRESCALE/BPER writes immediately; if the new limit is below the current count, the counter continues to its width maximum and wraps without firing tick or toggle.
REQ-022 SHALL make GEN=0 hold all counters at 0 and drive leds to all INV.
REQ-023 SHALL, on simultaneous read and write to the same address, return the old value.

Reset
REQ-024 SHALL, on reset_reset_n low, asynchronously clear all registers, shadows, active duties, counters, phase, readdata and leds to 0.
REQ-025 SHALL, on reset asserted mid-period, abandon the period; after release, counting restarts from 0 on the first edge with GEN=1.

Verification
REQ-026 Reset, then read 0x00..0x04 and 0x20 -> all return 0, leds=0.
REQ-027 NUM_LEDS=8, PWM_BITS=8, CTRL=1, EN=0x01, PRESCALE=0, DUTY[0]=64 -> leds[0] high 64 of every 256 cycles, 1-cycle output lag.
REQ-028 DUTY[0]=255 -> leds[0] constantly high; DUTY[0]=0 -> constantly low; INV=1 -> both inverted.
REQ-029 Mid-period write DUTY[0]=200 while 64 active -> current period stays 64 high, next period 200 high.
REQ-030 BLINK=0x01, BPER=1, PRESCALE=3 -> leds[0] PWM gated on 2 periods (2048 cycles), off 2048 cycles, repeating.
REQ-031 Assert reset_reset_n low mid-period with PRESCALE=5 -> leds=0 within the same cycle; after release, registers read 0.

Source files
------------

// File: rtl/custom_leds_pwm.sv
// Memory-mapped PWM LED controller with a prescaled period counter,
// double-buffered duty registers and a per-channel blink gate.
module custom_leds_pwm #(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk_clk,
    input  logic                reset_reset_n,
    input  logic [5:0]          avs_s0_address,
    input  logic                avs_s0_write,
    input  logic                avs_s0_read,
    input  logic [31:0]         avs_s0_writedata,
    output logic [31:0]         avs_s0_readdata,
    output logic [NUM_LEDS-1:0] leds
);

    localparam logic [PWM_BITS-1:0] DutyMax = '1;

    logic                gen_q;
    logic                inv_q;
    logic [NUM_LEDS-1:0] en_q;
    logic [NUM_LEDS-1:0] blink_q;
    logic [15:0]         prescale_q;
    logic [15:0]         bper_q;
    logic [PWM_BITS-1:0] duty_shadow_q [NUM_LEDS];
    logic [PWM_BITS-1:0] duty_active_q [NUM_LEDS];

    logic [15:0]         pcnt_q;
    logic [PWM_BITS-1:0] cnt_q;
    logic [15:0]         bcnt_q;
    logic                phase_q;

    logic [NUM_LEDS-1:0] leds_d, leds_q;
    logic [31:0]         rdata_d, rdata_q;

    logic wr_ctrl, wr_en, wr_blink, wr_prescale, wr_bper, wr_duty;
    logic clr, tick, boundary;

    always_comb begin
        wr_ctrl     = avs_s0_write && (avs_s0_address == 6'h00);
        wr_en       = avs_s0_write && (avs_s0_address == 6'h01);
        wr_blink    = avs_s0_write && (avs_s0_address == 6'h02);
        wr_prescale = avs_s0_write && (avs_s0_address == 6'h03);
        wr_bper     = avs_s0_write && (avs_s0_address == 6'h04);
        wr_duty     = avs_s0_write && avs_s0_address[5];
        clr         = wr_ctrl && avs_s0_writedata[2];
        tick        = gen_q && (pcnt_q == prescale_q);
        boundary    = tick && (cnt_q == DutyMax);
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            gen_q      <= 1'b0;
            inv_q      <= 1'b0;
            en_q       <= '0;
            blink_q    <= '0;
            prescale_q <= '0;
            bper_q     <= '0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                duty_shadow_q[i] <= '0;
            end
        end else begin
            if (wr_ctrl) begin
                gen_q <= avs_s0_writedata[0];
                inv_q <= avs_s0_writedata[1];
            end
            if (wr_en)       en_q       <= avs_s0_writedata[NUM_LEDS-1:0];
            if (wr_blink)    blink_q    <= avs_s0_writedata[NUM_LEDS-1:0];
            if (wr_prescale) prescale_q <= avs_s0_writedata[15:0];
            if (wr_bper)     bper_q     <= avs_s0_writedata[15:0];
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                if (wr_duty && (avs_s0_address[4:0] == 5'(i))) begin
                    duty_shadow_q[i] <= avs_s0_writedata[PWM_BITS-1:0];
                end
            end
        end
    end

    // Counters sit at a period start while disabled, so the active duty tracks the shadow.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            pcnt_q  <= '0;
            cnt_q   <= '0;
            bcnt_q  <= '0;
            phase_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                duty_active_q[i] <= '0;
            end
        end else begin
            if (clr || !gen_q) begin
                pcnt_q  <= '0;
                cnt_q   <= '0;
                bcnt_q  <= '0;
                phase_q <= 1'b0;
            end else if (tick) begin
                pcnt_q <= '0;
                cnt_q  <= cnt_q + PWM_BITS'(1);
                if (boundary) begin
                    if (bcnt_q == bper_q) begin
                        bcnt_q  <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        bcnt_q <= bcnt_q + 16'd1;
                    end
                end
            end else begin
                pcnt_q <= pcnt_q + 16'd1;
            end
            if (clr || !gen_q || boundary) begin
                for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                    duty_active_q[i] <= duty_shadow_q[i];
                end
            end
        end
    end

    always_comb begin
        leds_d = '0;
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
            leds_d[i] = gen_q && en_q[i]
                     && ((duty_active_q[i] == DutyMax) || (cnt_q < duty_active_q[i]))
                     && (!blink_q[i] || phase_q);
        end
        leds_d = leds_d ^ {NUM_LEDS{inv_q}};
    end

    // Mux reads the pre-write register values, so a same-cycle write returns old data.
    always_comb begin
        rdata_d = rdata_q;
        if (avs_s0_read) begin
            rdata_d = '0;
            case (avs_s0_address)
                6'h00:   rdata_d = {30'd0, inv_q, gen_q};
                6'h01:   rdata_d = 32'(en_q);
                6'h02:   rdata_d = 32'(blink_q);
                6'h03:   rdata_d = {16'd0, prescale_q};
                6'h04:   rdata_d = {16'd0, bper_q};
                default: begin
                    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                        if (avs_s0_address[5] && (avs_s0_address[4:0] == 5'(i))) begin
                            rdata_d = 32'(duty_shadow_q[i]);
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            leds_q  <= '0;
            rdata_q <= '0;
        end else begin
            leds_q  <= leds_d;
            rdata_q <= rdata_d;
        end
    end

    assign leds            = leds_q;
    assign avs_s0_readdata = rdata_q;

endmodule

// File: tb/tb_custom_leds_pwm.sv
// Bench for custom_leds_pwm: register access via a read scoreboard, PWM behaviour
// checked by counting high cycles of leds[0] over known windows.
module tb_custom_leds_pwm;

    logic        clk;
    logic        rst_n;
    logic [5:0]  addr;
    logic        wr;
    logic        rd;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [7:0]  leds;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    custom_leds_pwm #(
        .NUM_LEDS (8),
        .PWM_BITS (8)
    ) dut (
        .clk_clk          (clk),
        .reset_reset_n    (rst_n),
        .avs_s0_address   (addr),
        .avs_s0_write     (wr),
        .avs_s0_read      (rd),
        .avs_s0_writedata (wdata),
        .avs_s0_readdata  (rdata),
        .leds             (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // All bus tasks are entered just after a negedge and return at the next negedge.
    task automatic wr_reg(input logic [5:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        @(negedge clk);
        wr    = 1'b0;
    endtask

    task automatic rd_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
        addr = a;
        rd   = 1'b1;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        rd = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_empty"}, 32'd1, 32'd0);
        end else begin
            check(tag_q.pop_front(), rdata, exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic rw_reg(input string tag, input logic [5:0] a, input logic [31:0] d,
                          input logic [31:0] exp_old);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        rd    = 1'b1;
        exp_q.push_back(exp_old);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        check(tag_q.pop_front(), rdata, exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic count_highs(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(negedge clk);
            if (leds[0]) h++;
        end
    endtask

    int h, h1, h2;

    initial begin
        rst_n = 1'b0;
        addr  = '0;
        wr    = 1'b0;
        rd    = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        check("leds_in_reset", 32'(leds), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        rd_reg("rst_ctrl",     6'h00, 32'h0);
        rd_reg("rst_en",       6'h01, 32'h0);
        rd_reg("rst_blink",    6'h02, 32'h0);
        rd_reg("rst_prescale", 6'h03, 32'h0);
        rd_reg("rst_bper",     6'h04, 32'h0);
        rd_reg("rst_duty0",    6'h20, 32'h0);
        check("rst_leds", 32'(leds), 32'h0);

        wr_reg(6'h01, 32'hFFFF_FFA5);
        rd_reg("en_rb", 6'h01, 32'h0000_00A5);
        wr_reg(6'h02, 32'h0000_013C);
        rd_reg("blink_rb", 6'h02, 32'h0000_003C);
        wr_reg(6'h03, 32'h1234_5678);
        rd_reg("prescale_rb", 6'h03, 32'h0000_5678);
        wr_reg(6'h04, 32'hABCD_0009);
        rd_reg("bper_rb", 6'h04, 32'h0000_0009);
        wr_reg(6'h21, 32'h0000_01FF);
        rd_reg("duty1_rb", 6'h21, 32'h0000_00FF);
        wr_reg(6'h28, 32'h0000_0055);
        rd_reg("duty8_unmapped", 6'h28, 32'h0);
        wr_reg(6'h10, 32'hFFFF_FFFF);
        rd_reg("unmapped_10", 6'h10, 32'h0);
        wr_reg(6'h00, 32'h0000_0006);
        rd_reg("ctrl_clr_reads0", 6'h00, 32'h0000_0002);
        @(negedge clk);
        check("gen0_leds_inv", 32'(leds), 32'h0000_00FF);
        rw_reg("rw_old_value", 6'h03, 32'h0000_0000, 32'h0000_5678);
        rd_reg("rw_new_value", 6'h03, 32'h0);
        rd_reg("bper_again", 6'h04, 32'h0000_0009);
        repeat (3) @(negedge clk);
        check("rdata_hold", rdata, 32'h0000_0009);

        wr_reg(6'h00, 32'h0);
        wr_reg(6'h01, 32'h0000_0001);
        wr_reg(6'h02, 32'h0);
        wr_reg(6'h03, 32'h0);
        wr_reg(6'h04, 32'h0);
        wr_reg(6'h21, 32'h0);

        // 25% duty, prescale 0: leds[0] high for samples 1..64 after the clear edge.
        wr_reg(6'h20, 32'd64);
        wr_reg(6'h00, 32'h5);
        check("lag_before_first", 32'(leds[0]), 32'h0);
        h = 0;
        for (int n = 1; n <= 256; n++) begin
            @(negedge clk);
            if (leds[0]) h++;
            if (n == 1)  check("lag_first_high", 32'(leds[0]), 32'h1);
            if (n == 64) check("last_high", 32'(leds[0]), 32'h1);
            if (n == 65) check("first_low", 32'(leds[0]), 32'h0);
        end
        check("duty64_p1", h, 64);
        count_highs(256, h);
        check("duty64_p2", h, 64);

        wr_reg(6'h20, 32'd255);
        wr_reg(6'h00, 32'h5);
        count_highs(256, h);
        check("duty255", h, 256);
        wr_reg(6'h20, 32'd0);
        wr_reg(6'h00, 32'h5);
        count_highs(256, h);
        check("duty0", h, 0);
        wr_reg(6'h20, 32'd255);
        wr_reg(6'h00, 32'h7);
        count_highs(256, h);
        check("duty255_inv", h, 0);
        wr_reg(6'h20, 32'd0);
        wr_reg(6'h00, 32'h7);
        count_highs(256, h);
        check("duty0_inv", h, 256);

        // Duty written mid-period takes effect only from the next period.
        wr_reg(6'h20, 32'd64);
        wr_reg(6'h00, 32'h5);
        count_highs(9, h1);
        wr_reg(6'h20, 32'd200);
        count_highs(246, h2);
        check("midwrite_cur", h1 + h2, 63);
        count_highs(256, h);
        check("midwrite_next", h, 200);

        // Blink: period 1024 cycles, phase toggles every two periods.
        wr_reg(6'h03, 32'd3);
        wr_reg(6'h04, 32'd1);
        wr_reg(6'h02, 32'h1);
        wr_reg(6'h20, 32'd64);
        wr_reg(6'h00, 32'h5);
        count_highs(2048, h);
        check("blink_off1", h, 0);
        count_highs(2048, h);
        check("blink_on", h, 512);
        count_highs(2048, h);
        check("blink_off2", h, 0);

        wr_reg(6'h02, 32'h0);
        wr_reg(6'h03, 32'd5);
        wr_reg(6'h20, 32'd255);
        wr_reg(6'h00, 32'h5);
        repeat (37) @(negedge clk);
        check("pre_reset_high", 32'(leds[0]), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_async_leds", 32'(leds), 32'h0);
        check("reset_async_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_reg("post_rst_ctrl",     6'h00, 32'h0);
        rd_reg("post_rst_en",       6'h01, 32'h0);
        rd_reg("post_rst_prescale", 6'h03, 32'h0);
        rd_reg("post_rst_duty0",    6'h20, 32'h0);
        check("post_rst_leds", 32'(leds), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
